// File: rtl/quad_decoder_counter.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder_counter
// Purpose  : Quadrature (A/B) encoder decoder with an integrated WIDTH-bit
//            up/down position counter. x4 resolution: one count per phase
//            edge. Includes parallel load, direction and step indication,
//            wrap pulses and a sticky illegal-transition error flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   a_in     in   encoder phase A (asynchronous to clk)
//   b_in     in   encoder phase B (asynchronous to clk)
//   enable   in   0: decoded steps do not move count (tracking continues)
//   load     in   synchronous parallel load of data_in into count
//   data_in  in   [WIDTH] load value
//   err_clr  in   synchronous clear of err
//   count    out  [WIDTH] current position
//   dir      out  direction of last valid step (1 = up, 0 = down)
//   step     out  one-cycle pulse per valid decoded step
//   wrap     out  one-cycle pulse when count wraps in either direction
//   err      out  sticky illegal-transition flag
// ============================================================================
module quad_decoder_counter #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] c_count_max = '1;

    logic [SYNC_STAGES-1:0] r_a_sync;
    logic [SYNC_STAGES-1:0] r_b_sync;
    // Marks how far real input samples have propagated through the
    // synchronizer since reset; the cleared flops must never be decoded.
    logic [SYNC_STAGES-1:0] r_fill;
    logic [1:0]             r_prev;
    logic                   r_primed;

    logic [1:0] w_s;
    logic       w_sync_valid;
    logic       w_up;
    logic       w_dn;
    logic       w_illegal;

    assign w_s          = {r_a_sync[SYNC_STAGES-1], r_b_sync[SYNC_STAGES-1]};
    assign w_sync_valid = r_fill[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Synchronizer and priming. Priming waits until the last sync stage
    // holds a genuine sample; otherwise the reset value of the flops would
    // look like a phase change against the real encoder position.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sync <= '0;
            r_b_sync <= '0;
            r_fill   <= '0;
            r_prev   <= 2'b00;
            r_primed <= 1'b0;
        end else begin
            r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], a_in};
            r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], b_in};
            r_fill   <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev   <= w_s;
            if (w_sync_valid) begin
                r_primed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transition decode of {prev, current}. Gray-code neighbours are
    // steps; a change of both bits at once is an illegal jump.
    // ------------------------------------------------------------------
    always_comb begin
        w_up      = 1'b0;
        w_dn      = 1'b0;
        w_illegal = 1'b0;
        if (r_primed) begin
            case ({r_prev, w_s})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: w_up      = 1'b1;
                4'b0010, 4'b1011, 4'b1101, 4'b0100: w_dn      = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: w_illegal = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counter, indications and error flag.
    // step/dir report every decoded step even when load or !enable keep
    // count from moving.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= w_up | w_dn;

            if (w_up) begin
                dir <= 1'b1;
            end else if (w_dn) begin
                dir <= 1'b0;
            end

            if (load) begin
                count <= data_in;
                wrap  <= 1'b0;
            end else if (enable && w_up) begin
                count <= count + 1'b1;
                wrap  <= (count == c_count_max);
            end else if (enable && w_dn) begin
                count <= count - 1'b1;
                wrap  <= (count == '0);
            end else begin
                wrap  <= 1'b0;
            end

            // A new illegal jump takes precedence over a clear.
            if (w_illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_decoder_counter
// Purpose  : Self-checking bench for quad_decoder_counter (WIDTH=4,
//            SYNC_STAGES=2). Table of phase vectors plus hand sequences for
//            load priority, error set/clear and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_decoder_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_in;
    logic       b_in;
    logic       enable;
    logic       load;
    logic [3:0] data_in;
    logic       err_clr;
    logic [3:0] count;
    logic       dir;
    logic       step;
    logic       wrap;
    logic       err;

    int total = 0;
    int bad   = 0;

    quad_decoder_counter #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a_in    (a_in),
        .b_in    (b_in),
        .enable  (enable),
        .load    (load),
        .data_in (data_in),
        .err_clr (err_clr),
        .count   (count),
        .dir     (dir),
        .step    (step),
        .wrap    (wrap),
        .err     (err)
    );

    always #5 clk = ~clk;

    // One phase value held for four cycles; step/wrap expected only on the
    // third edge after the change, the rest checked after the hold.
    typedef struct {
        logic [1:0] ab;
        logic       en;
        logic       st;
        logic       wr;
        logic [3:0] cnt;
        logic       dr;
        logic       er;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] v);
        load    = 1'b1;
        data_in = v;
        @(negedge clk);
        load = 1'b0;
        chk("load count", 32'(count), 32'(v));
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            {a_in, b_in} = vecs[k].ab;
            enable       = vecs[k].en;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk($sformatf("v%0d step c%0d", k, i), 32'(step), 32'(vecs[k].st && (i == 2)));
                chk($sformatf("v%0d wrap c%0d", k, i), 32'(wrap), 32'(vecs[k].wr && (i == 2)));
            end
            chk($sformatf("v%0d count", k), 32'(count), 32'(vecs[k].cnt));
            chk($sformatf("v%0d dir", k),   32'(dir),   32'(vecs[k].dr));
            chk($sformatf("v%0d err", k),   32'(err),   32'(vecs[k].er));
        end
    endtask

    initial begin
        //            ab     en    st    wr    cnt   dr    er
        vecs[0]  = '{2'b01, 1'b1, 1'b1, 1'b0, 4'd1,  1'b1, 1'b0};
        vecs[1]  = '{2'b11, 1'b1, 1'b1, 1'b0, 4'd2,  1'b1, 1'b0};
        vecs[2]  = '{2'b10, 1'b1, 1'b1, 1'b0, 4'd3,  1'b1, 1'b0};
        vecs[3]  = '{2'b00, 1'b1, 1'b1, 1'b0, 4'd4,  1'b1, 1'b0};
        vecs[4]  = '{2'b01, 1'b1, 1'b1, 1'b0, 4'd5,  1'b1, 1'b0};
        // after load 14
        vecs[5]  = '{2'b11, 1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0};
        vecs[6]  = '{2'b10, 1'b1, 1'b1, 1'b1, 4'd0,  1'b1, 1'b0};
        vecs[7]  = '{2'b00, 1'b1, 1'b1, 1'b0, 4'd1,  1'b1, 1'b0};
        vecs[8]  = '{2'b10, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[9]  = '{2'b11, 1'b1, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0};
        // after load 6: down step to 5
        vecs[10] = '{2'b01, 1'b1, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0};
        // illegal 11 -> 00
        vecs[11] = '{2'b00, 1'b1, 1'b0, 1'b0, 4'd10, 1'b1, 1'b1};
        // enable low: steps reported, count frozen
        vecs[12] = '{2'b01, 1'b0, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0};
        vecs[13] = '{2'b11, 1'b0, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0};
        vecs[14] = '{2'b01, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 1'b0};
        // first step after re-priming
        vecs[15] = '{2'b00, 1'b1, 1'b1, 1'b0, 4'd1,  1'b1, 1'b0};

        reset   = 1'b1;
        a_in    = 1'b1;
        b_in    = 1'b1;
        enable  = 1'b1;
        load    = 1'b0;
        data_in = 4'd0;
        err_clr = 1'b0;

        // Reset state and priming with phases at 11
        repeat (3) @(negedge clk);
        chk("reset count", 32'(count), 32'd0);
        chk("reset dir",   32'(dir),   32'd0);
        chk("reset step",  32'(step),  32'd0);
        chk("reset wrap",  32'(wrap),  32'd0);
        chk("reset err",   32'(err),   32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("prime step c%0d", i), 32'(step), 32'd0);
        end
        chk("prime count", 32'(count), 32'd0);
        chk("prime err",   32'(err),   32'd0);

        // Restart from phase 00 for the counting sequences
        {a_in, b_in} = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("restart count", 32'(count), 32'd0);

        run_vecs(0, 4);
        do_load(4'd14);
        run_vecs(5, 9);
        do_load(4'd6);
        run_vecs(10, 10);

        // Load lands on the same edge as a decoded up step (01 -> 11)
        {a_in, b_in} = 2'b11;
        @(negedge clk);
        @(negedge clk);
        load    = 1'b1;
        data_in = 4'd10;
        @(negedge clk);
        load = 1'b0;
        chk("ldpri count", 32'(count), 32'd10);
        chk("ldpri step",  32'(step),  32'd1);
        chk("ldpri dir",   32'(dir),   32'd1);
        chk("ldpri wrap",  32'(wrap),  32'd0);
        @(negedge clk);
        chk("ldpri hold count", 32'(count), 32'd10);
        chk("ldpri hold step",  32'(step),  32'd0);

        run_vecs(11, 11);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("errclr err", 32'(err), 32'd0);

        run_vecs(12, 14);

        // Illegal jump 01 -> 10 coinciding with err_clr: set wins
        enable       = 1'b1;
        {a_in, b_in} = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("setwin pre err", 32'(err), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("setwin err",   32'(err),   32'd1);
        chk("setwin count", 32'(count), 32'd10);

        // Reset between clock edges at count 7
        do_load(4'd7);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst err",   32'(err),   32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("reprime step c%0d", i), 32'(step), 32'd0);
        end
        chk("reprime count", 32'(count), 32'd0);
        chk("reprime dir",   32'(dir),   32'd0);

        run_vecs(15, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
